pcie_us_axi_slave_wr: RTL and testbench

AXI4 write slave that converts each AXI write burst into one or more PCIe Memory Write TLPs on an UltraScale requester request (RQ) AXI stream. It is the outbound counterpart of the CQ-to-AXI write master: on-chip AXI masters use it to post writes onto the PCIe link. Bursts are split at the current Max Payload Size (MPS). One OKAY write response is returned per burst after its final TLP beat is accepted.

---
 rtl/pcie_us_axi_slave_wr_if.sv | 61 ++++++
 rtl/pcie_us_axi_slave_wr.sv | 167 ++++++++++++++++
 tb/tb_pcie_us_axi_slave_wr.sv | 462 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pcie_us_axi_slave_wr_if.sv
// AXI4 write-slave channels plus UltraScale RQ stream for pcie_us_axi_slave_wr.
// slave is the bridge side, master is the side driving AXI and sinking RQ.
interface pcie_us_axi_slave_wr_if #(
  parameter int unsigned AXIS_PCIE_DATA_WIDTH    = 64,
  parameter int unsigned AXIS_PCIE_KEEP_WIDTH    = 2,
  parameter int unsigned AXIS_PCIE_RQ_USER_WIDTH = 60,
  parameter int unsigned AXI_DATA_WIDTH          = 64,
  parameter int unsigned AXI_ADDR_WIDTH          = 64,
  parameter int unsigned AXI_STRB_WIDTH          = 8,
  parameter int unsigned AXI_ID_WIDTH            = 8
);
  logic [AXI_ID_WIDTH-1:0]            s_axi_awid;
  logic [AXI_ADDR_WIDTH-1:0]          s_axi_awaddr;
  logic [7:0]                         s_axi_awlen;
  logic [2:0]                         s_axi_awsize;
  logic [1:0]                         s_axi_awburst;
  logic                               s_axi_awlock;
  logic [3:0]                         s_axi_awcache;
  logic [2:0]                         s_axi_awprot;
  logic                               s_axi_awvalid;
  logic                               s_axi_awready;
  logic [AXI_DATA_WIDTH-1:0]          s_axi_wdata;
  logic [AXI_STRB_WIDTH-1:0]          s_axi_wstrb;
  logic                               s_axi_wlast;
  logic                               s_axi_wvalid;
  logic                               s_axi_wready;
  logic [AXI_ID_WIDTH-1:0]            s_axi_bid;
  logic [1:0]                         s_axi_bresp;
  logic                               s_axi_bvalid;
  logic                               s_axi_bready;
  logic [AXIS_PCIE_DATA_WIDTH-1:0]    m_axis_rq_tdata;
  logic [AXIS_PCIE_KEEP_WIDTH-1:0]    m_axis_rq_tkeep;
  logic                               m_axis_rq_tvalid;
  logic                               m_axis_rq_tready;
  logic                               m_axis_rq_tlast;
  logic [AXIS_PCIE_RQ_USER_WIDTH-1:0] m_axis_rq_tuser;

  modport slave (
    input  s_axi_awid, s_axi_awaddr, s_axi_awlen, s_axi_awsize, s_axi_awburst, s_axi_awlock,
           s_axi_awcache, s_axi_awprot, s_axi_awvalid,
    output s_axi_awready,
    input  s_axi_wdata, s_axi_wstrb, s_axi_wlast, s_axi_wvalid,
    output s_axi_wready,
    output s_axi_bid, s_axi_bresp, s_axi_bvalid,
    input  s_axi_bready,
    output m_axis_rq_tdata, m_axis_rq_tkeep, m_axis_rq_tvalid, m_axis_rq_tlast, m_axis_rq_tuser,
    input  m_axis_rq_tready
  );

  modport master (
    output s_axi_awid, s_axi_awaddr, s_axi_awlen, s_axi_awsize, s_axi_awburst, s_axi_awlock,
           s_axi_awcache, s_axi_awprot, s_axi_awvalid,
    input  s_axi_awready,
    output s_axi_wdata, s_axi_wstrb, s_axi_wlast, s_axi_wvalid,
    input  s_axi_wready,
    input  s_axi_bid, s_axi_bresp, s_axi_bvalid,
    output s_axi_bready,
    input  m_axis_rq_tdata, m_axis_rq_tkeep, m_axis_rq_tvalid, m_axis_rq_tlast, m_axis_rq_tuser,
    output m_axis_rq_tready
  );
endinterface

// File: rtl/pcie_us_axi_slave_wr.sv
// AXI4 write slave that posts each burst as one or more PCIe MWr TLPs on a 64-bit RQ
// stream, splitting at Max Payload Size and returning one OKAY response per burst.
module pcie_us_axi_slave_wr #(
  parameter int unsigned AXIS_PCIE_DATA_WIDTH    = 64,
  parameter int unsigned AXIS_PCIE_KEEP_WIDTH    = 2,
  parameter int unsigned AXIS_PCIE_RQ_USER_WIDTH = 60,
  parameter int unsigned AXI_DATA_WIDTH          = 64,
  parameter int unsigned AXI_ADDR_WIDTH          = 64,
  parameter int unsigned AXI_STRB_WIDTH          = 8,
  parameter int unsigned AXI_ID_WIDTH            = 8,
  parameter int unsigned AXI_MAX_BURST_LEN       = 256
) (
  input  logic                   clk,
  input  logic                   rst,
  pcie_us_axi_slave_wr_if.slave  bus,
  input  logic [2:0]             max_payload_size,
  output logic                   status_error_strb
);

  localparam int unsigned CntW = $clog2(AXI_MAX_BURST_LEN + 1);

  typedef enum logic [2:0] {StIdle, StDesc0, StDesc1, StData, StResp} state_e;

  state_e                    state_q, state_d;
  logic [AXI_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [CntW-1:0]           rem_q, rem_d;
  logic [CntW-1:0]           chunk_q, chunk_d;
  logic [CntW-1:0]           cnt_q, cnt_d;
  logic [AXI_ID_WIDTH-1:0]   bid_q, bid_d;
  logic                      awready_q, awready_d;
  logic                      bvalid_q, bvalid_d;

  logic [2:0]                mps_c;
  logic [CntW:0]             mps_beats;
  logic [CntW-1:0]           chunk_c;
  logic [AXI_DATA_WIDTH-1:0] wdata_c;
  logic                      beat_hs;
  logic                      unused_in;

  assign unused_in = ^{bus.s_axi_awaddr[2:0], bus.s_axi_awsize, bus.s_axi_awburst,
                       bus.s_axi_awlock, bus.s_axi_awcache, bus.s_axi_awprot, bus.s_axi_wlast};
  assign wdata_c   = bus.s_axi_wdata;
  assign beat_hs   = bus.s_axi_wvalid && bus.m_axis_rq_tready;

  // Beats per TLP at the current MPS; encodings above 4096 bytes clamp to 4096.
  always_comb begin
    mps_c     = (max_payload_size > 3'd5) ? 3'd5 : max_payload_size;
    mps_beats = (CntW + 1)'(16) << mps_c;
    chunk_c   = ({1'b0, rem_q} < mps_beats) ? rem_q : mps_beats[CntW-1:0];
  end

  assign bus.s_axi_awready = awready_q;
  assign bus.s_axi_bvalid  = bvalid_q;
  assign bus.s_axi_bid     = bid_q;
  assign bus.s_axi_bresp   = 2'b00;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    rem_d     = rem_q;
    chunk_d   = chunk_q;
    cnt_d     = cnt_q;
    bid_d     = bid_q;
    awready_d = awready_q;
    bvalid_d  = bvalid_q;

    bus.s_axi_wready      = 1'b0;
    bus.m_axis_rq_tvalid  = 1'b0;
    bus.m_axis_rq_tdata   = {AXIS_PCIE_DATA_WIDTH{1'b0}};
    bus.m_axis_rq_tkeep   = {AXIS_PCIE_KEEP_WIDTH{1'b0}};
    bus.m_axis_rq_tlast   = 1'b0;
    bus.m_axis_rq_tuser   = {AXIS_PCIE_RQ_USER_WIDTH{1'b0}};
    status_error_strb     = 1'b0;

    case (state_q)
      StIdle: begin
        if (bus.s_axi_awvalid && awready_q) begin
          addr_d    = {bus.s_axi_awaddr[AXI_ADDR_WIDTH-1:3], 3'b000};
          rem_d     = CntW'(bus.s_axi_awlen) + CntW'(1);
          bid_d     = bus.s_axi_awid;
          awready_d = 1'b0;
          state_d   = StDesc0;
        end else begin
          awready_d = 1'b1;
        end
      end
      StDesc0: begin
        // Byte enables come from the first W beat, which is only peeked here.
        bus.m_axis_rq_tvalid     = bus.s_axi_wvalid;
        bus.m_axis_rq_tdata      = AXIS_PCIE_DATA_WIDTH'({addr_q[AXI_ADDR_WIDTH-1:2], 2'b00});
        bus.m_axis_rq_tkeep      = {AXIS_PCIE_KEEP_WIDTH{1'b1}};
        bus.m_axis_rq_tuser[3:0] = bus.s_axi_wstrb[3:0];
        bus.m_axis_rq_tuser[7:4] = (chunk_c == CntW'(1)) ? bus.s_axi_wstrb[7:4] : 4'hF;
        if (beat_hs) begin
          chunk_d = chunk_c;
          state_d = StDesc1;
        end
      end
      StDesc1: begin
        bus.m_axis_rq_tvalid       = 1'b1;
        bus.m_axis_rq_tkeep        = {AXIS_PCIE_KEEP_WIDTH{1'b1}};
        bus.m_axis_rq_tdata[10:0]  = 11'({chunk_q, 1'b0});
        bus.m_axis_rq_tdata[14:11] = 4'b0001;
        if (bus.m_axis_rq_tready) begin
          cnt_d   = '0;
          state_d = StData;
        end
      end
      StData: begin
        bus.m_axis_rq_tvalid = bus.s_axi_wvalid;
        bus.s_axi_wready     = bus.m_axis_rq_tready;
        bus.m_axis_rq_tdata  = AXIS_PCIE_DATA_WIDTH'(wdata_c);
        bus.m_axis_rq_tkeep  = {AXIS_PCIE_KEEP_WIDTH{1'b1}};
        bus.m_axis_rq_tlast  = (cnt_q == chunk_q - CntW'(1));
        if (beat_hs) begin
          if (cnt_q == '0) begin
            status_error_strb = (bus.s_axi_wstrb[3:0] == 4'h0);
          end else begin
            status_error_strb = (bus.s_axi_wstrb != {AXI_STRB_WIDTH{1'b1}});
          end
          cnt_d = cnt_q + CntW'(1);
          if (bus.m_axis_rq_tlast) begin
            addr_d = addr_q + AXI_ADDR_WIDTH'({chunk_q, 3'b000});
            rem_d  = rem_q - chunk_q;
            if (rem_q == chunk_q) begin
              bvalid_d = 1'b1;
              state_d  = StResp;
            end else begin
              state_d  = StDesc0;
            end
          end
        end
      end
      StResp: begin
        if (bvalid_q && bus.s_axi_bready) begin
          bvalid_d  = 1'b0;
          awready_d = 1'b1;
          state_d   = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      addr_q    <= '0;
      rem_q     <= '0;
      chunk_q   <= '0;
      cnt_q     <= '0;
      bid_q     <= '0;
      awready_q <= 1'b0;
      bvalid_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      rem_q     <= rem_d;
      chunk_q   <= chunk_d;
      cnt_q     <= cnt_d;
      bid_q     <= bid_d;
      awready_q <= awready_d;
      bvalid_q  <= bvalid_d;
    end
  end

endmodule

// File: tb/tb_pcie_us_axi_slave_wr.sv
// Randomized bench for pcie_us_axi_slave_wr: a burst-level model predicts the RQ beat
// stream, strobe-error positions and B response for each AXI burst.
module tb_pcie_us_axi_slave_wr;

  localparam int Limit = 3000;

  typedef struct packed {
    logic [63:0] data;
    logic [1:0]  keep;
    logic        last;
    logic [59:0] user;
  } beat_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [2:0] mps;
  logic       err;

  always #5 clk = ~clk;

  pcie_us_axi_slave_wr_if bus ();

  pcie_us_axi_slave_wr dut (
    .clk               (clk),
    .rst               (rst),
    .bus               (bus),
    .max_payload_size  (mps),
    .status_error_strb (err)
  );

  int          vectors = 0;
  int          errors  = 0;
  beat_t       exp_q[$];
  beat_t       obs_q[$];
  int          exp_err[$];
  int          obs_err[$];
  logic [63:0] wd[$];
  logic [7:0]  ws[$];
  int          beat_idx;
  int          b_cnt;
  logic [7:0]  b_id;
  logic [1:0]  b_resp;
  bit          bp_en = 0;
  bit          abort = 0;
  bit          tmo   = 0;

  // Sink-side handshakes, randomized when backpressure is enabled.
  initial begin
    bus.m_axis_rq_tready = 1'b1;
    bus.s_axi_bready     = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bus.m_axis_rq_tready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.s_axi_bready     = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: captures RQ beats, error pulses and B responses; checks stalled beats hold.
  initial begin
    beat_t prev, cur;
    bit    prev_stall;
    prev_stall = 0;
    prev       = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 0;
      end else begin
        cur.data = bus.m_axis_rq_tdata;
        cur.keep = bus.m_axis_rq_tkeep;
        cur.last = bus.m_axis_rq_tlast;
        cur.user = bus.m_axis_rq_tuser;
        if (prev_stall) begin
          vectors++;
          if (bus.m_axis_rq_tvalid !== 1'b1 || cur !== prev) begin
            errors++;
            $display("FAIL stall_hold: tvalid=%b beat=%h required tvalid=1 beat=%h",
                     bus.m_axis_rq_tvalid, cur, prev);
          end
        end
        if (err === 1'b1) obs_err.push_back((bus.m_axis_rq_tvalid && bus.m_axis_rq_tready) ?
                                            beat_idx : -1);
        if (bus.m_axis_rq_tvalid && bus.m_axis_rq_tready) begin
          obs_q.push_back(cur);
          beat_idx++;
        end
        prev_stall = bus.m_axis_rq_tvalid && !bus.m_axis_rq_tready;
        prev       = cur;
        if (bus.s_axi_bvalid && bus.s_axi_bready) begin
          b_cnt++;
          b_id   = bus.s_axi_bid;
          b_resp = bus.s_axi_bresp;
        end
      end
    end
  end

  // Burst-level reference: split into MPS-sized TLPs, two descriptor beats then data.
  task automatic model(input logic [63:0] addr, input int len, input logic [2:0] m);
    int          mpsb = 16 << ((m > 3'd5) ? 5 : int'(m));
    logic [63:0] a    = addr & ~64'h7;
    int          rem  = len + 1;
    int          idx  = 0;
    int          c;
    beat_t       b;
    while (rem > 0) begin
      c           = (rem < mpsb) ? rem : mpsb;
      b.data      = a;
      b.keep      = 2'b11;
      b.last      = 1'b0;
      b.user      = '0;
      b.user[3:0] = ws[idx][3:0];
      b.user[7:4] = (c == 1) ? ws[idx][7:4] : 4'hF;
      exp_q.push_back(b);
      b.data      = 64'(c * 2) | 64'h800;
      b.user      = '0;
      exp_q.push_back(b);
      for (int k = 0; k < c; k++) begin
        b.data = wd[idx+k];
        b.last = (k == c - 1);
        if ((k == 0) ? (ws[idx][3:0] == 4'h0) : (ws[idx+k] != 8'hFF))
          exp_err.push_back(exp_q.size());
        exp_q.push_back(b);
      end
      idx += c;
      a   += 64'(c * 8);
      rem -= c;
    end
  endtask

  // Drives one AW + its W beats and waits for the B response. Starts and ends at posedge+1.
  task automatic run_burst(input logic [63:0] addr, input int len, input logic [7:0] id,
                           input logic [7:0] first_strb, input int bad_beat,
                           input logic [7:0] bad_strb);
    obs_q.delete(); exp_q.delete(); obs_err.delete(); exp_err.delete();
    wd.delete(); ws.delete();
    beat_idx = 0;
    b_cnt    = 0;
    tmo      = 0;
    for (int i = 0; i <= len; i++) begin
      wd.push_back({$urandom, $urandom});
      ws.push_back((i == 0) ? first_strb : ((i == bad_beat) ? bad_strb : 8'hFF));
    end
    model(addr, len, mps);
    fork
      begin : aw_drv
        bit hs;
        int t;
        hs = 0;
        t  = 0;
        bus.s_axi_awid    = id;
        bus.s_axi_awaddr  = addr;
        bus.s_axi_awlen   = 8'(len);
        bus.s_axi_awvalid = 1'b1;
        while (!hs && !abort) begin
          @(negedge clk);
          hs = bus.s_axi_awvalid && bus.s_axi_awready;
          @(posedge clk);
          #1;
          t++;
          if (t > Limit) begin
            tmo = 1;
            break;
          end
        end
        bus.s_axi_awvalid = 1'b0;
      end
      begin : w_drv
        bit hs;
        int t;
        for (int i = 0; i <= len; i++) begin
          if (bp_en) begin
            bus.s_axi_wvalid = 1'b0;
            repeat ($urandom_range(0, 1)) begin
              @(posedge clk);
              #1;
            end
          end
          if (abort || tmo) break;
          bus.s_axi_wdata  = wd[i];
          bus.s_axi_wstrb  = ws[i];
          bus.s_axi_wlast  = (i == len);
          bus.s_axi_wvalid = 1'b1;
          hs = 0;
          t  = 0;
          while (!hs && !abort) begin
            @(negedge clk);
            hs = bus.s_axi_wvalid && bus.s_axi_wready;
            @(posedge clk);
            #1;
            t++;
            if (t > Limit) begin
              tmo = 1;
              break;
            end
          end
        end
        bus.s_axi_wvalid = 1'b0;
      end
      begin : b_wait
        int t;
        for (t = 0; t < Limit * 2 && b_cnt == 0 && !abort; t++) @(negedge clk);
        if (b_cnt == 0 && !abort) tmo = 1;
        repeat (4) @(negedge clk);
      end
    join
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if ({bus.s_axi_awready, bus.s_axi_wready, bus.s_axi_bvalid, bus.s_axi_bid, bus.s_axi_bresp,
         bus.m_axis_rq_tvalid, bus.m_axis_rq_tlast, bus.m_axis_rq_tkeep, bus.m_axis_rq_tdata,
         bus.m_axis_rq_tuser, err} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: awready=%b tvalid=%b bvalid=%b tdata=%h required all 0",
               bus.s_axi_awready, bus.m_axis_rq_tvalid, bus.s_axi_bvalid, bus.m_axis_rq_tdata);
    end
    rst = 1'b0;
    vectors++;
    if (bus.s_axi_awready !== 1'b0) begin
      errors++;
      $display("FAIL reset_release_awready: got %b required 0", bus.s_axi_awready);
    end
    @(posedge clk);
    #1;
    vectors++;
    if (bus.s_axi_awready !== 1'b1) begin
      errors++;
      $display("FAIL reset_first_edge_awready: got %b required 1", bus.s_axi_awready);
    end
  endtask

  task automatic test_single();
    mps = 3'd0;
    run_burst(64'h1000, 0, 8'h5A, 8'h3C, -1, 8'h00);
    vectors++;
    if (tmo || obs_q.size() != 3 || obs_q[0].data !== 64'h1000 || obs_q[0].user[7:0] !== 8'h3C ||
        obs_q[1].data[15:0] !== 16'h0802 || obs_q[2].last !== 1'b1 || obs_q[2].data !== wd[0]) begin
      errors++;
      $display("FAIL single_tlp: tmo=%0d beats=%0d d0=%h u0=%h d1=%h required 3 beats 1000 3c 0802",
               tmo, obs_q.size(), obs_q[0].data, obs_q[0].user[7:0], obs_q[1].data[15:0]);
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      vectors++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL single_beat%0d: got %h required %h", i, obs_q[i], exp_q[i]);
      end
    end
    vectors++;
    if (b_cnt != 1 || b_id !== 8'h5A || b_resp !== 2'b00 || obs_err.size() != 0) begin
      errors++;
      $display("FAIL single_bresp: count=%0d bid=%h bresp=%b errs=%0d required 1 5a 00 0",
               b_cnt, b_id, b_resp, obs_err.size());
    end
  endtask

  task automatic test_split();
    mps = 3'd0;
    run_burst(64'h2000, 63, 8'h11, 8'hFF, -1, 8'h00);
    vectors++;
    if (tmo || obs_q.size() != 72 || b_cnt != 1) begin
      errors++;
      $display("FAIL split_count: tmo=%0d beats=%0d bresps=%0d required 72 beats 1 bresp",
               tmo, obs_q.size(), b_cnt);
    end
    for (int k = 0; k < 4; k++) begin
      vectors++;
      if (obs_q[18*k].data !== 64'h2000 + 64'(k * 128) || obs_q[18*k+1].data[15:0] !== 16'h0820 ||
          obs_q[18*k+17].last !== 1'b1 || obs_q[18*k+16].last !== 1'b0) begin
        errors++;
        $display("FAIL split_tlp%0d: addr=%h dw=%h required addr=%h dw=0820", k,
                 obs_q[18*k].data, obs_q[18*k+1].data[15:0], 64'h2000 + 64'(k * 128));
      end
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      vectors++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL split_beat%0d: got %h required %h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_mps(input logic [2:0] m, input int len, input logic [15:0] dw,
                          input int beats);
    mps = m;
    run_burst(64'h2000, len, 8'h22, 8'hFF, -1, 8'h00);
    vectors++;
    if (tmo || obs_q.size() != beats || obs_q[1].data[15:0] !== dw || b_cnt != 1) begin
      errors++;
      $display("FAIL mps%0d_tlp: tmo=%0d beats=%0d dw=%h required %0d beats dw=%h", m, tmo,
               obs_q.size(), obs_q[1].data[15:0], beats, dw);
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      vectors++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL mps%0d_beat%0d: got %h required %h", m, i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    mps   = 3'd0;
    bp_en = 1;
    run_burst({32'h0, $urandom} & ~64'hFFF, 31, 8'h33, 8'hFF, -1, 8'h00);
    bp_en = 0;
    vectors++;
    if (tmo || obs_q.size() != exp_q.size() || b_cnt != 1 || b_id !== 8'h33) begin
      errors++;
      $display("FAIL bp_count: tmo=%0d beats=%0d bresps=%0d bid=%h required %0d 1 33", tmo,
               obs_q.size(), b_cnt, b_id, exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      vectors++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL bp_beat%0d: got %h required %h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_strobe_error();
    mps = 3'd0;
    run_burst(64'h3000, 3, 8'h44, 8'hFF, 2, 8'h0F);
    vectors++;
    if (tmo || obs_q.size() != 6 || obs_err.size() != 1 || obs_err[0] != 4) begin
      errors++;
      $display("FAIL strobe_err: tmo=%0d beats=%0d pulses=%0d at=%0d required 6 beats 1 pulse at 4",
               tmo, obs_q.size(), obs_err.size(), obs_err[0]);
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      vectors++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL strobe_beat%0d: got %h required %h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    mps = 3'd0;
    fork
      run_burst(64'h4000, 15, 8'h55, 8'hFF, -1, 8'h00);
      begin
        int t;
        for (t = 0; t < Limit && obs_q.size() < 5; t++) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        vectors++;
        if (t >= Limit || {bus.s_axi_awready, bus.s_axi_wready, bus.s_axi_bvalid,
                           bus.m_axis_rq_tvalid, bus.m_axis_rq_tlast, bus.m_axis_rq_tkeep,
                           bus.m_axis_rq_tdata, bus.m_axis_rq_tuser, err} !== '0) begin
          errors++;
          $display("FAIL midreset_outputs: wait=%0d tvalid=%b wready=%b tdata=%h required all 0",
                   t, bus.m_axis_rq_tvalid, bus.s_axi_wready, bus.m_axis_rq_tdata);
        end
        abort = 1;
      end
    join
    @(posedge clk);
    #1;
    rst   = 1'b0;
    abort = 0;
    vectors++;
    if (bus.s_axi_awready !== 1'b0) begin
      errors++;
      $display("FAIL midreset_release: awready=%b required 0", bus.s_axi_awready);
    end
    @(posedge clk);
    #1;
    vectors++;
    if (bus.s_axi_awready !== 1'b1) begin
      errors++;
      $display("FAIL midreset_awready: awready=%b required 1", bus.s_axi_awready);
    end
    run_burst(64'h5008, 0, 8'h66, 8'hF1, -1, 8'h00);
    vectors++;
    if (tmo || obs_q.size() != 3 || b_cnt != 1 || b_id !== 8'h66) begin
      errors++;
      $display("FAIL midreset_after: tmo=%0d beats=%0d bresps=%0d bid=%h required 3 1 66", tmo,
               obs_q.size(), b_cnt, b_id);
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      vectors++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL midreset_beat%0d: got %h required %h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 8; n++) begin
      int len;
      len   = $urandom_range(0, 40);
      mps   = 3'($urandom_range(0, 7));
      bp_en = 1'($urandom_range(0, 1));
      run_burst({$urandom, $urandom}, len, 8'($urandom), 8'($urandom), $urandom_range(0, len),
                8'($urandom));
      bp_en = 0;
      vectors++;
      if (tmo || obs_q.size() != exp_q.size() || b_cnt != 1 || obs_err.size() != exp_err.size())
      begin
        errors++;
        $display("FAIL rand%0d_count: tmo=%0d beats=%0d errs=%0d bresps=%0d required %0d %0d 1",
                 n, tmo, obs_q.size(), obs_err.size(), b_cnt, exp_q.size(), exp_err.size());
      end
      for (int i = 0; i < exp_err.size(); i++) begin
        vectors++;
        if (obs_err[i] != exp_err[i]) begin
          errors++;
          $display("FAIL rand%0d_err%0d: at %0d required %0d", n, i, obs_err[i], exp_err[i]);
        end
      end
      for (int i = 0; i < exp_q.size(); i++) begin
        vectors++;
        if (obs_q[i] !== exp_q[i]) begin
          errors++;
          $display("FAIL rand%0d_beat%0d: got %h required %h", n, i, obs_q[i], exp_q[i]);
        end
      end
    end
  endtask

  initial begin
    mps                = 3'd0;
    bus.s_axi_awid     = '0;
    bus.s_axi_awaddr   = '0;
    bus.s_axi_awlen    = '0;
    bus.s_axi_awsize   = 3'd3;
    bus.s_axi_awburst  = 2'b01;
    bus.s_axi_awlock   = 1'b0;
    bus.s_axi_awcache  = 4'h0;
    bus.s_axi_awprot   = 3'h0;
    bus.s_axi_awvalid  = 1'b0;
    bus.s_axi_wdata    = '0;
    bus.s_axi_wstrb    = '0;
    bus.s_axi_wlast    = 1'b0;
    bus.s_axi_wvalid   = 1'b0;
    #1 rst = 1'b1;
    test_reset();
    test_single();
    test_split();
    test_mps(3'd2, 63, 16'h0880, 66);
    test_mps(3'd7, 255, 16'h0A00, 258);
    test_backpressure();
    test_strobe_error();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
